// File: rtl/tlul_scratchpad_ram.sv
// TL-UL device-side scratchpad RAM placed directly behind xbar_main.
// Byte-masked writes and full-word reads on a synchronous single-port array,
// with an in-order response buffer of Outstanding entries.
// Optional request checking: define TLUL_SCRATCHPAD_ERR_EN to flag bad requests
// via d_error; otherwise addresses alias modulo Depth and d_error stays 0.

package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = 4;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    localparam tl_d_user_t TL_D_USER_DEFAULT = '0;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_d_user_t        d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

module tlul_scratchpad_ram #(
    parameter int    Depth       = 16384,
    parameter int    Outstanding = 2,
    parameter string MemInitFile = ""
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o
);

    import tlul_pkg::*;

    localparam int AW   = $clog2(Depth);
    localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int CntW = $clog2(Outstanding + 1);

    // One buffered response; pend marks a Get whose word is still in rd_q.
    typedef struct packed {
        logic              get;
        logic [TL_AIW-1:0] source;
        logic [TL_SZW-1:0] size;
        logic              error;
        logic              pend;
        logic [TL_DW-1:0]  data;
    } entry_t;

    logic [TL_DW-1:0] mem [Depth];
    logic [TL_DW-1:0] rd_q;

    entry_t           buf_q [Outstanding];
    logic [PtrW-1:0]  head_q;
    logic [PtrW-1:0]  tail_q;
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_next;
    logic             a_ready_q;

    logic [AW-1:0]    idx;
    logic             req_get;
    logic             req_err;
    logic             accept;
    logic             pop;
    logic             do_write;
    logic             do_read;
    entry_t           new_entry;
    entry_t           head;
    logic             unused_bits;

    assign idx     = tl_i.a_address[2 +: AW];
    assign req_get = (tl_i.a_opcode == Get);

`ifdef TLUL_SCRATCHPAD_ERR_EN
    logic op_ok;
    logic addr_ok;
    logic size_ok;
    logic full_ok;

    // Reject unknown opcodes, out-of-range addresses, oversized beats and
    // PutFullData word writes that do not enable every byte lane.
    always_comb begin
        op_ok   = (tl_i.a_opcode == Get) || (tl_i.a_opcode == PutFullData) ||
                  (tl_i.a_opcode == PutPartialData);
        addr_ok = (tl_i.a_address[TL_AW-1:AW+2] == '0);
        size_ok = (tl_i.a_size <= TL_SZW'(2));
        full_ok = !((tl_i.a_opcode == PutFullData) && (tl_i.a_size == TL_SZW'(2)) &&
                    (tl_i.a_mask != 4'hF));
        req_err = !(op_ok && addr_ok && size_ok && full_ok);
    end
`else
    assign req_err = 1'b0;
`endif

    // Sub-word address bits, a_param and integrity user bits are not consumed.
    assign unused_bits = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address};

    assign accept   = tl_i.a_valid && a_ready_q;
    assign pop      = (count_q != '0) && tl_i.d_ready;
    assign do_write = accept && !req_get && !req_err;
    assign do_read  = accept && req_get && !req_err;

    // Single-port array: at most one byte-masked write or one word read per edge.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int b = 0; b < TL_DBW; b++) begin
                if (tl_i.a_mask[b]) begin
                    mem[idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
                end
            end
        end
        if (do_read) begin
            rd_q <= mem[idx];
        end
    end

    // Response descriptor built from the request being accepted.
    always_comb begin
        new_entry        = '0;
        new_entry.get    = req_get;
        new_entry.source = tl_i.a_source;
        new_entry.size   = tl_i.a_size;
        new_entry.error  = req_err;
        new_entry.pend   = do_read;
    end

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Outstanding - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign count_next = count_q + CntW'(accept) - CntW'(pop);

    // Response FIFO; a_ready is registered so a pop only reopens it next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Outstanding; i++) begin
                buf_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            a_ready_q <= 1'b0;
        end else begin
            // Read data lives in rd_q for one cycle only; fold it into the entry
            // so a stalled response keeps its data without re-reading the array.
            for (int i = 0; i < Outstanding; i++) begin
                if (buf_q[i].pend) begin
                    buf_q[i].pend <= 1'b0;
                    buf_q[i].data <= rd_q;
                end
            end
            if (accept) begin
                buf_q[tail_q] <= new_entry;
                tail_q        <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            count_q   <= count_next;
            a_ready_q <= (count_next < CntW'(Outstanding));
        end
    end

    assign head = buf_q[head_q];

    // Drive channel D from the buffer head; all fields read zero when empty.
    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready_q;
        tl_o.d_user  = TL_D_USER_DEFAULT;
        if (count_q != '0) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = head.get ? AccessAckData : AccessAck;
            tl_o.d_size   = head.size;
            tl_o.d_source = head.source;
            tl_o.d_error  = head.error;
            tl_o.d_data   = head.pend ? rd_q : head.data;
        end
    end

endmodule
